smg_scan_ctrl: RTL and testbench

Parametrised successor to the taxi-meter combinational seven-segment driver. Generates its own digit-scan timing from the system clock and shows the fee or distance BCD value on N_DIGITS multiplexed digits. Adds frame-coherent value snapshot, leading-zero blanking, a decimal point and a blink mode. Sits between the fare/distance counters and the board digit decoder, replacing the external Bit_Sel scan counter.

---
 rtl/smg_pkg.sv | 32 +++
 rtl/smg_seg_decode.sv | 10 +
 rtl/smg_scan_ctrl.sv | 89 ++++++++
 tb/tb_smg_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: seven-segment codes and BCD decode helper shared by display blocks
// Codes are active-high: bit7 = dp, bits6:0 = g..a.
package smg_pkg;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int DP_BIT = 7;
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/smg_seg_decode.sv
// smg_seg_decode: combinational BCD nibble to segment code, dp left clear
// Ports: nibble (4b BCD in), seg (8b active-high code out; A-F show a dash).
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  assign seg = bcd_to_seg(nibble);
endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: multiplexed BCD display scanner with frame snapshot, blanking, dp and blink
// Ports: clk, rst (sync, active-high), d_m (0 fee / 1 distance), fee, distance (packed BCD,
// MS nibble on top), blink_en; seg (dp + g..a), an (active digit, 0 = MSD), frame_start.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int DP_FEE = 2,
  parameter int DP_DIST = 1,
  parameter int LZ_BLANK = 1,
  localparam int AN_W = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_m,
  input  logic [4*N_DIGITS-1:0] fee,
  input  logic [4*N_DIGITS-1:0] distance,
  input  logic                  blink_en,
  output logic [7:0]            seg,
  output logic [AN_W-1:0]       an,
  output logic                  frame_start
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] pre;
  logic [AN_W-1:0] idx;
  logic [BW-1:0] bcnt;
  logic phase, snap_sel, tick_q, tick, last, wrap, lz, pt, run;
  logic [4*N_DIGITS-1:0] snap_val;
  logic [3:0] nib;
  logic [7:0] dig_seg, seg_next;
  int dp;
  assign tick = pre == PW'(SCAN_DIV - 1);
  assign last = idx == AN_W'(N_DIGITS - 1);
  assign wrap = tick && last;
  assign dp = snap_sel ? DP_DIST : DP_FEE;
  assign pt = dp > 0 && int'(idx) == N_DIGITS - 1 - dp;
  // run tracks "this and every more significant nibble is zero"; digits at or
  // right of the point digit and the LSD are never blanked.
  always_comb begin
    nib = 4'd0;
    lz = 1'b0;
    run = LZ_BLANK != 0;
    for (int i = 0; i < N_DIGITS; i++) begin
      run = run && snap_val[4*(N_DIGITS-1-i) +: 4] == 4'd0;
      if (AN_W'(i) == idx) begin
        nib = snap_val[4*(N_DIGITS-1-i) +: 4];
        lz = run && i < N_DIGITS - 1 && (dp == 0 || i < N_DIGITS - 1 - dp);
      end
    end
  end
  smg_seg_decode u_dec (.nibble(nib), .seg(dig_seg));
  assign seg_next = (blink_en && phase) || lz ? SEG_BLANK : dig_seg | (pt ? 8'(1 << DP_BIT) : 8'h00);
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      snap_sel <= 1'b0;
      snap_val <= '0;
      tick_q <= 1'b0;
      seg <= SEG_BLANK;
      an <= '0;
      frame_start <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      tick_q <= tick;
      if (tick) idx <= last ? '0 : idx + 1'b1;
      if (wrap) begin
        snap_sel <= d_m;
        snap_val <= d_m ? distance : fee;
      end
      if (!blink_en) begin
        bcnt <= '0;
        phase <= 1'b0;
      end else if (wrap) begin
        bcnt <= bcnt == BW'(BLINK_FRAMES - 1) ? '0 : bcnt + 1'b1;
        if (bcnt == BW'(BLINK_FRAMES - 1)) phase <= ~phase;
      end
      // outputs trail idx by one clock so an, seg and frame_start move together
      an <= idx;
      seg <= seg_next;
      frame_start <= tick_q && idx == '0;
    end
  end
endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl: directed self-checking bench for smg_scan_ctrl (4 digits, 4 clocks per slot, 2-frame blink)
module tb_smg_scan_ctrl;
  logic clk = 1'b0;
  logic rst, d_m, blink_en;
  logic [15:0] fee, distance;
  logic [7:0] seg;
  logic [1:0] an;
  logic frame_start;
  int tests = 0;
  int fails = 0;
  logic [7:0] cap_seg [4];
  logic [1:0] cap_an [4];
  int cap_fs;
  smg_scan_ctrl #(
    .N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .DP_FEE(2), .DP_DIST(1), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .d_m(d_m), .fee(fee), .distance(distance), .blink_en(blink_en),
    .seg(seg), .an(an), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  // Called on the negedge where frame_start is high; returns on the next such negedge.
  task automatic capture();
    cap_fs = 0;
    for (int d = 0; d < 4; d++) begin
      cap_an[d] = an;
      cap_seg[d] = seg;
      for (int c = 0; c < 4; c++) begin
        cap_fs += int'(frame_start);
        @(negedge clk);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; d_m = 1'b0; blink_en = 1'b0; fee = 16'h1234; distance = 16'h0000;
    repeat (4) @(negedge clk);
    tests++;
    if (seg !== 8'h00 || an !== 2'd0 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset: seg=%h an=%0d fs=%b, want 00 0 0", seg, an, frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (seg !== 8'h00 || an !== 2'd0) begin
      fails++;
      $display("FAIL first_slot: seg=%h an=%0d, want 00 0", seg, an);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (seg !== 8'hBF || an !== 2'd1) begin
      fails++;
      $display("FAIL zero_snapshot: seg=%h an=%0d, want bf 1", seg, an);
    end
    repeat (11) @(negedge clk);
    tests++;
    if (frame_start !== 1'b0 || an !== 2'd3) begin
      fails++;
      $display("FAIL pre_wrap: fs=%b an=%0d, want 0 3", frame_start, an);
    end
    @(negedge clk);
    tests++;
    if (frame_start !== 1'b1 || an !== 2'd0) begin
      fails++;
      $display("FAIL frame_start: fs=%b an=%0d, want 1 0", frame_start, an);
    end
  endtask
  task automatic test_scan();
    logic [7:0] exp [4];
    exp = '{8'h06, 8'hDB, 8'h4F, 8'h66};
    capture();
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (cap_an[d] !== 2'(d) || cap_seg[d] !== exp[d]) begin
        fails++;
        $display("FAIL scan[%0d]: an=%0d seg=%h, want an=%0d seg=%h", d, cap_an[d], cap_seg[d], d, exp[d]);
      end
    end
    tests++;
    if (cap_fs !== 1 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL frame_period: pulses=%0d fs_now=%b, want 1 1", cap_fs, frame_start);
    end
  endtask
  task automatic test_snapshot();
    logic [7:0] exp [4];
    exp = '{8'h6D, 8'hFD, 8'h07, 8'h7F};
    repeat (4) @(negedge clk);
    fee = 16'h5678;
    tests++;
    if (an !== 2'd1 || seg !== 8'hDB) begin
      fails++;
      $display("FAIL snap_d1: an=%0d seg=%h, want 1 db", an, seg);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (seg !== 8'h4F) begin
      fails++;
      $display("FAIL snap_d2: seg=%h, want 4f", seg);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (seg !== 8'h66) begin
      fails++;
      $display("FAIL snap_d3: seg=%h, want 66", seg);
    end
    repeat (4) @(negedge clk);
    capture();
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (cap_seg[d] !== exp[d]) begin
        fails++;
        $display("FAIL snap_next[%0d]: seg=%h, want %h", d, cap_seg[d], exp[d]);
      end
    end
  endtask
  task automatic test_blank();
    logic [7:0] exp [4];
    fee = 16'h0005;
    capture();
    capture();
    exp = '{8'h00, 8'hBF, 8'h3F, 8'h6D};
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (cap_seg[d] !== exp[d]) begin
        fails++;
        $display("FAIL blank_fee[%0d]: seg=%h, want %h", d, cap_seg[d], exp[d]);
      end
    end
    distance = 16'h00A0;
    d_m = 1'b1;
    capture();
    capture();
    exp = '{8'h00, 8'h00, 8'hC0, 8'h3F};
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (cap_seg[d] !== exp[d]) begin
        fails++;
        $display("FAIL blank_dist[%0d]: seg=%h, want %h", d, cap_seg[d], exp[d]);
      end
    end
  endtask
  task automatic test_switch();
    logic [7:0] exp [4];
    exp = '{8'h00, 8'hBF, 8'h3F, 8'h6D};
    repeat (8) @(negedge clk);
    d_m = 1'b0;
    tests++;
    if (an !== 2'd2 || seg !== 8'hC0) begin
      fails++;
      $display("FAIL switch_d2: an=%0d seg=%h, want 2 c0", an, seg);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (seg !== 8'h3F) begin
      fails++;
      $display("FAIL switch_d3: seg=%h, want 3f", seg);
    end
    repeat (4) @(negedge clk);
    capture();
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (cap_seg[d] !== exp[d]) begin
        fails++;
        $display("FAIL switch_next[%0d]: seg=%h, want %h", d, cap_seg[d], exp[d]);
      end
    end
  endtask
  task automatic test_blink();
    logic [7:0] exp [4];
    logic blank;
    exp = '{8'h06, 8'hDB, 8'h4F, 8'h66};
    fee = 16'h1234;
    capture();
    blink_en = 1'b1;
    for (int f = 0; f < 7; f++) begin
      blank = f == 2 || f == 3 || f == 6;
      capture();
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (cap_an[d] !== 2'(d) || cap_seg[d] !== (blank ? 8'h00 : exp[d])) begin
          fails++;
          $display("FAIL blink f%0d d%0d: an=%0d seg=%h, want an=%0d seg=%h", f, d, cap_an[d], cap_seg[d], d, blank ? 8'h00 : exp[d]);
        end
      end
    end
    tests++;
    if (seg !== 8'h00 || an !== 2'd0) begin
      fails++;
      $display("FAIL blink_f7: an=%0d seg=%h, want 0 00", an, seg);
    end
    blink_en = 1'b0;
    @(negedge clk);
    tests++;
    if (seg !== 8'h06) begin
      fails++;
      $display("FAIL unblink: seg=%h, want 06", seg);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (an !== 2'd1 || seg !== 8'hDB) begin
      fails++;
      $display("FAIL unblink_next: an=%0d seg=%h, want 1 db", an, seg);
    end
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 40 && an !== 2'd2; i++) @(negedge clk);
    tests++;
    if (an !== 2'd2) begin
      fails++;
      $display("FAIL reach_an2: an=%0d, want 2", an);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (an !== 2'd0 || seg !== 8'h00 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: an=%0d seg=%h fs=%b, want 0 00 0", an, seg, frame_start);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (an !== 2'd0) begin
      fails++;
      $display("FAIL resume_hold: an=%0d, want 0", an);
    end
    @(negedge clk);
    tests++;
    if (an !== 2'd1 || seg !== 8'hBF) begin
      fails++;
      $display("FAIL resume: an=%0d seg=%h, want 1 bf", an, seg);
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_switch();
    test_blink();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
